// File: rtl/button_conditioner.sv
// Push-button front end: per-channel two-flop synchroniser, counter debounce,
// press pulse, processor-clearable sticky flag and a global press counter.
module button_conditioner #(
  parameter int NUM_BTN         = 9,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               clr_en,
  input  logic [NUM_BTN-1:0] clr_mask,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_BTN-1:0] btn_sticky,
  output logic [31:0]        press_word,
  output logic [7:0]         press_count
);

  // Raw pin level of a released button; the synchroniser resets to it so that
  // leaving reset never looks like a press.
  localparam logic [NUM_BTN-1:0] REL_LEVEL =
    (ACTIVE_LOW != 0) ? {NUM_BTN{1'b1}} : {NUM_BTN{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] sync_q1;
  logic [NUM_BTN-1:0] sync_q2;
  logic [NUM_BTN-1:0] pressed_s2;

  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] level_d;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];

  logic [NUM_BTN-1:0] pulse_q;
  logic [NUM_BTN-1:0] pulse_d;
  logic [NUM_BTN-1:0] sticky_q;
  logic [NUM_BTN-1:0] sticky_d;
  logic [7:0]         count_q;
  logic [7:0]         count_d;
  logic [7:0]         pop_d;

  // Sync stays in the raw-pin domain; polarity is folded in after stage 2.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_q1 <= REL_LEVEL;
      sync_q2 <= REL_LEVEL;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign pressed_s2 = (ACTIVE_LOW != 0) ? ~sync_q2 : sync_q2;

  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (pressed_s2[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = pressed_s2[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    pulse_d  = level_d & ~level_q;
    // A press landing in the same cycle as its clear keeps the flag set.
    sticky_d = pulse_d | (sticky_q & ~(clr_mask & {NUM_BTN{clr_en}}));

    pop_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      pop_d = pop_d + 8'(pulse_d[i]);
    end
    count_d = count_q + pop_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      level_q  <= '0;
      pulse_q  <= '0;
      sticky_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    press_word              = '0;
    press_word[NUM_BTN-1:0] = sticky_q;
  end

  assign btn_level   = level_q;
  assign btn_pulse   = pulse_q;
  assign btn_sticky  = sticky_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a 4-cycle debounce and
// active-low pins; expected values are worked out by hand per step.
module tb_button_conditioner;

  localparam int NB = 9;

  logic          clock;
  logic          resetn;
  logic [NB-1:0] btn_raw;
  logic          clr_en;
  logic [NB-1:0] clr_mask;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;
  logic [NB-1:0] btn_sticky;
  logic [31:0]   press_word;
  logic [7:0]    press_count;

  int vectors = 0;
  int errs    = 0;

  button_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(1)
  ) dut (
    .clock(clock), .resetn(resetn), .btn_raw(btn_raw),
    .clr_en(clr_en), .clr_mask(clr_mask),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .btn_sticky(btn_sticky),
    .press_word(press_word), .press_count(press_count)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges, landing 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".level"},  32'(btn_level),   32'h0);
    chk({tag, ".pulse"},  32'(btn_pulse),   32'h0);
    chk({tag, ".sticky"}, 32'(btn_sticky),  32'h0);
    chk({tag, ".word"},   press_word,       32'h0);
    chk({tag, ".count"},  32'(press_count), 32'h0);
  endtask

  // Press the masked buttons cleanly, hold through acceptance, then release
  // and wait for the release to be accepted as well.
  task automatic press_release(input logic [NB-1:0] mask);
    btn_raw = btn_raw & ~mask;
    tick(8);
    btn_raw = btn_raw | mask;
    tick(8);
  endtask

  initial begin
    btn_raw  = '1;
    clr_en   = 1'b0;
    clr_mask = '0;
    resetn   = 1'b0;

    // 1. reset and idle
    tick(3);
    chk_all_zero("t1_in_reset");
    resetn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      chk("t1_idle_pulse", 32'(btn_pulse), 32'h0);
      chk("t1_idle_word",  press_word,     32'h0);
    end
    chk_all_zero("t1_idle_end");

    // 2. clean press on button 0: accepted on the 6th edge
    btn_raw[0] = 1'b0;
    tick(5);
    chk("t2_level_early", 32'(btn_level), 32'h0);
    chk("t2_pulse_early", 32'(btn_pulse), 32'h0);
    tick(1);
    chk("t2_level",  32'(btn_level),   32'h001);
    chk("t2_pulse",  32'(btn_pulse),   32'h001);
    chk("t2_count",  32'(press_count), 32'd1);
    tick(1);
    chk("t2_pulse_one_cycle", 32'(btn_pulse),  32'h0);
    chk("t2_sticky",          32'(btn_sticky), 32'h001);
    chk("t2_word",            press_word,      32'h1);
    chk("t2_count_hold",      32'(press_count), 32'd1);
    btn_raw[0] = 1'b1;
    tick(5);
    chk("t2_release_not_yet", 32'(btn_level), 32'h001);
    tick(1);
    chk("t2_release_level", 32'(btn_level),   32'h0);
    chk("t2_release_pulse", 32'(btn_pulse),   32'h0);
    chk("t2_release_count", 32'(press_count), 32'd1);

    // 3. bounce on button 3: low 3, high 1, then low; accepted on edge 10
    btn_raw[3] = 1'b0;
    tick(3);
    btn_raw[3] = 1'b1;
    tick(1);
    btn_raw[3] = 1'b0;
    for (int k = 5; k <= 9; k++) begin
      tick(1);
      chk("t3_no_early_pulse", 32'(btn_pulse), 32'h0);
    end
    chk("t3_level_early", 32'(btn_level), 32'h0);
    tick(1);
    chk("t3_pulse", 32'(btn_pulse),   32'h008);
    chk("t3_count", 32'(press_count), 32'd2);
    tick(1);
    chk("t3_single_pulse", 32'(btn_pulse),  32'h0);
    chk("t3_sticky",       32'(btn_sticky), 32'h009);
    btn_raw[3] = 1'b1;
    tick(8);
    chk("t3_release_count", 32'(press_count), 32'd2);

    // 4. clear colliding with a new press of button 0: set wins
    btn_raw[0] = 1'b0;
    tick(5);
    clr_en   = 1'b1;
    clr_mask = 9'h001;
    tick(1);
    chk("t4_pulse", 32'(btn_pulse), 32'h001);
    clr_en   = 1'b0;
    clr_mask = '0;
    tick(1);
    chk("t4_set_wins", 32'(btn_sticky),  32'h009);
    chk("t4_count",    32'(press_count), 32'd3);
    clr_en = 1'b1;
    tick(1);
    clr_en = 1'b0;
    tick(1);
    chk("t4_mask0_no_effect", 32'(btn_sticky), 32'h009);
    clr_en   = 1'b1;
    clr_mask = 9'h001;
    tick(1);
    clr_en   = 1'b0;
    clr_mask = '0;
    chk("t4_cleared", 32'(btn_sticky), 32'h008);
    chk("t4_word",    press_word,      32'h8);
    clr_en   = 1'b1;
    clr_mask = 9'h001;
    tick(1);
    clr_en   = 1'b0;
    clr_mask = '0;
    chk("t4_clear_again", 32'(btn_sticky), 32'h008);
    btn_raw[0] = 1'b1;
    tick(8);

    // 5. bring press_count to 250, then press all nine at once
    press_release(9'h00F);
    chk("t5_count_7", 32'(press_count), 32'd7);
    for (int r = 0; r < 27; r++) press_release(9'h1FF);
    chk("t5_count_250", 32'(press_count), 32'd250);
    clr_en   = 1'b1;
    clr_mask = 9'h1FF;
    tick(1);
    clr_en   = 1'b0;
    clr_mask = '0;
    chk("t5_word_cleared", press_word, 32'h0);
    btn_raw = '0;
    tick(6);
    chk("t5_pulse_all", 32'(btn_pulse),   32'h1FF);
    chk("t5_count_wrap", 32'(press_count), 32'd3);
    tick(1);
    chk("t5_word_all", press_word,       32'h1FF);
    chk("t5_pulse_off", 32'(btn_pulse),  32'h0);
    btn_raw = '1;
    tick(8);
    chk("t5_release_count", 32'(press_count), 32'd3);

    // 6. reset while button 5 is mid-debounce (C=2 after 4 edges)
    btn_raw[5] = 1'b0;
    tick(4);
    chk("t6_not_yet", 32'(btn_level), 32'h0);
    resetn = 1'b0;
    #1;
    chk_all_zero("t6_reset_async");
    tick(2);
    chk_all_zero("t6_reset_held");
    resetn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      chk("t6_no_early_pulse", 32'(btn_pulse), 32'h0);
    end
    tick(1);
    chk("t6_pulse", 32'(btn_pulse),   32'h020);
    chk("t6_count", 32'(press_count), 32'd1);
    tick(1);
    chk("t6_pulse_off", 32'(btn_pulse),  32'h0);
    chk("t6_sticky",    32'(btn_sticky), 32'h020);
    chk("t6_word",      press_word,      32'h20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
